bitcount_arbiter: RTL and testbench

//  Shared, multi-cycle bit-count engine (the hardware form of $countones/$countbits).
//  - Arbitrates round-robin between NREQ requesters.
//  - For the granted requester, counts the bits of a WIDTH-bit word that equal a

---
 rtl/bitcount_arbiter.sv | 155 +++++++++++++++
 tb/tb_bitcount_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitcount_arbiter.sv
// bitcount_arbiter: shared multi-cycle bit-count engine.
// Round-robin arbitrates NREQ requesters, then counts the bits of the granted
// word that equal the requested match value, STEP bits per cycle. The result
// and the requester id are returned on a valid/ready response port.

// One popcount slice: number of bits in 'bits' equal to 'match'
module bitcount_slice #(
    parameter int STEP = 4,
    parameter int CW   = 5
) (
    input  logic [STEP-1:0] bits,
    input  logic            match,
    output logic [CW-1:0]   cnt
);
    logic [STEP-1:0] hit;

    // XNOR marks matching bits, then shift-and-add them up
    always_comb begin
        hit = bits ~^ {STEP{match}};
        cnt = '0;
        for (int b = 0; b < STEP; b++) begin
            cnt = cnt + CW'(hit[0]);
            hit = hit >> 1;
        end
    end
endmodule

module bitcount_arbiter #(
    parameter int  NREQ  = 2,
    parameter int  WIDTH = 16,
    parameter int  STEP  = 4,   // WIDTH must be a multiple of STEP
    localparam int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_match,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [CW-1:0]         rsp_count
);
    localparam int K  = WIDTH / STEP;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]       state;
    logic [IDW-1:0]   last_grant;   // also the id of the operation in flight
    logic [WIDTH-1:0] word;
    logic             match_bit;
    logic [KW-1:0]    idx;
    logic [CW-1:0]    acc;

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   scan;
    logic [NREQ-1:0]   onehot;
    int                off;
    logic              gnt_any;
    logic [IDW-1:0]    gnt;
    logic [WIDTH-1:0]  gword;
    logic              gmatch;

    logic [STEP-1:0]   slice_bits;
    logic [CW-1:0]     slice_cnt;
    logic [CW-1:0]     acc_next;

    // Round-robin pick: rotate valids so last_grant+1 sits at bit 0, take the first set bit
    always_comb begin
        dbl     = {req_valid, req_valid};
        rot     = NREQ'(dbl >> ({1'b0, last_grant} + 1'b1));
        scan    = rot;
        gnt_any = 1'b0;
        off     = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && scan[0]) begin
                gnt_any = 1'b1;
                off     = k;
            end
            scan = scan >> 1;
        end
        gnt    = IDW'((int'(last_grant) + 1 + off) % NREQ);
        onehot = NREQ'(1) << gnt;
        gword  = WIDTH'(req_data >> (int'(gnt) * WIDTH));
        gmatch = |(req_match & onehot);
    end

    // Accept is only offered while idle; everyone else sees ready low
    always_comb begin
        req_ready = (state == S_IDLE && gnt_any) ? onehot : '0;
    end

    // Current STEP-wide slice of the captured word feeds the shared popcount slice
    always_comb begin
        slice_bits = STEP'(word >> (int'(idx) * STEP));
        acc_next   = acc + slice_cnt;
    end

    bitcount_slice #(.STEP(STEP), .CW(CW)) u_slice (
        .bits  (slice_bits),
        .match (match_bit),
        .cnt   (slice_cnt)
    );

    // Control FSM: IDLE accepts and captures, COUNT walks K slices, RESP holds the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= IDW'(NREQ - 1);
            word       <= '0;
            match_bit  <= 1'b0;
            idx        <= '0;
            acc        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        word       <= gword;
                        match_bit  <= gmatch;
                        acc        <= '0;
                        idx        <= '0;
                        last_grant <= gnt;
                        state      <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    acc <= acc_next;
                    idx <= idx + KW'(1);
                    if (idx == KW'(K - 1)) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_count <= acc_next;
                        rsp_id    <= last_grant;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitcount_arbiter.sv
// Bench for bitcount_arbiter (NREQ=2, WIDTH=16, STEP=4).
// Requester queues feed the DUT; a negedge recorder logs accepts/responses and
// steps a transaction-level model (round-robin rule + bit counting) for expectations.
module tb_bitcount_arbiter;
    localparam int NREQ = 2, WIDTH = 16, STEP = 4, K = WIDTH / STEP;
    localparam int IDW = 1, CW = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_match = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [IDW-1:0]        rsp_id;
    logic [CW-1:0]         rsp_count;

    bitcount_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_match(req_match),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_count(rsp_count)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int gnt; int egnt; } acc_t;
    typedef struct { int cyc; int id; int cnt; } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    rsp_t exp_q[$];
    int   rise_q[$];
    logic [WIDTH:0] rq0[$];
    logic [WIDTH:0] rq1[$];

    int cyc = 0;
    int n_checks = 0, n_pass = 0;
    int m_last = NREQ - 1;
    int rdy_bad = 0, hold_viol = 0;
    logic [NREQ-1:0] pend_pop = '0;
    bit   rdy_rand = 1'b0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    int   prev_id = 0, prev_cnt = 0;

    // Model: first valid requester after the last grant, wrapping
    function automatic int model_rr(int last, logic [NREQ-1:0] v);
        logic [NREQ-1:0] t;
        for (int k = 1; k <= NREQ; k++) begin
            t = v >> ((last + k) % NREQ);
            if (t[0]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Model: how many bits of d equal m
    function automatic int exp_count(logic [WIDTH-1:0] d, logic m);
        int n = 0;
        logic [WIDTH-1:0] t = d;
        for (int b = 0; b < WIDTH; b++) begin
            if (t[0] == m) n++;
            t = t >> 1;
        end
        return n;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: present the head of each queue, pop after an accept
    always @(posedge clk) begin
        #1;
        if (pend_pop[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (pend_pop[1] && rq1.size() > 0) void'(rq1.pop_front());
        pend_pop = '0;
        req_valid = {rq1.size() > 0, rq0.size() > 0};
        if (rq0.size() > 0) {req_match[0], req_data[15:0]}  = rq0[0];
        if (rq1.size() > 0) {req_match[1], req_data[31:16]} = rq1[0];
        if (rdy_rand) rsp_ready = ($urandom_range(0, 1) == 1);
    end

    // Recorder: logs events and steps the model; comparisons happen in the tests
    always @(negedge clk) begin
        int gi, eg;
        if (rst_n) begin
            if (req_ready != '0) begin
                gi = $clog2(req_ready);
                if ($countones(req_ready) != 1 || !((req_valid >> gi) & 1)) rdy_bad++;
                eg = model_rr(m_last, req_valid);
                acc_q.push_back('{cyc, gi, eg});
                if (eg >= 0) begin
                    exp_q.push_back('{0, eg, exp_count(eg == 1 ? req_data[31:16] : req_data[15:0],
                                                       eg == 1 ? req_match[1] : req_match[0])});
                    m_last = eg;
                end
                pend_pop[gi] = 1'b1;
            end
            if (rsp_valid && req_ready != '0) rdy_bad++;
            if (rsp_valid && !prev_v) rise_q.push_back(cyc);
            if (prev_v && !prev_r && (rsp_valid !== 1'b1 || int'(rsp_id) != prev_id ||
                                      int'(rsp_count) != prev_cnt)) hold_viol++;
            if (rsp_valid && rsp_ready) rsp_q.push_back('{cyc, int'(rsp_id), int'(rsp_count)});
            prev_v = rsp_valid; prev_r = rsp_ready;
            prev_id = int'(rsp_id); prev_cnt = int'(rsp_count);
        end
    end

    task automatic clear_logs();
        acc_q.delete(); rsp_q.delete(); exp_q.delete(); rise_q.delete();
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk); #1;
            if (rsp_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_id !== '0) $display("FAIL reset_id got=%0d want=0", rsp_id); else n_pass++;
        n_checks++; if (rsp_count !== '0) $display("FAIL reset_count got=%0d want=0", rsp_count); else n_pass++;
        n_checks++; if (req_ready !== '0) $display("FAIL reset_ready got=%b want=00", req_ready); else n_pass++;
        @(posedge clk); #2 rst_n = 1'b1;
        m_last = NREQ - 1;
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        rq0.push_back({1'b1, 16'h00F1});
        wait_rsp(1, ok);
        n_checks++; if (!ok) $display("FAIL single_timeout got=%0d rsp want=1", rsp_q.size()); else n_pass++;
        if (ok) begin
            n_checks++; if (acc_q[0].gnt !== 0) $display("FAIL single_grant got=%0d want=0", acc_q[0].gnt); else n_pass++;
            n_checks++; if (rise_q[0] - acc_q[0].cyc !== K + 1) $display("FAIL single_latency got=%0d want=%0d", rise_q[0] - acc_q[0].cyc, K + 1); else n_pass++;
            n_checks++; if (rsp_q[0].id !== 0 || rsp_q[0].cnt !== 5) $display("FAIL single_result got id=%0d cnt=%0d want id=0 cnt=5", rsp_q[0].id, rsp_q[0].cnt); else n_pass++;
            n_checks++; if (rsp_q[0].cnt !== exp_q[0].cnt) $display("FAIL single_model got=%0d want=%0d", rsp_q[0].cnt, exp_q[0].cnt); else n_pass++;
        end
    endtask

    task automatic test_match_zero();
        bit ok;
        clear_logs();
        rq1.push_back({1'b0, 16'hFFFF});
        rq1.push_back({1'b0, 16'h0000});
        wait_rsp(2, ok);
        n_checks++; if (!ok) $display("FAIL zero_timeout got=%0d rsp want=2", rsp_q.size()); else n_pass++;
        if (ok) begin
            n_checks++; if (rsp_q[0].id !== 1 || rsp_q[0].cnt !== 0) $display("FAIL zero_ffff got id=%0d cnt=%0d want id=1 cnt=0", rsp_q[0].id, rsp_q[0].cnt); else n_pass++;
            n_checks++; if (rsp_q[1].id !== 1 || rsp_q[1].cnt !== 16) $display("FAIL zero_0000 got id=%0d cnt=%0d want id=1 cnt=16", rsp_q[1].id, rsp_q[1].cnt); else n_pass++;
        end
    endtask

    task automatic test_alternate();
        bit ok;
        int want_ids[4] = '{0, 1, 0, 1};
        clear_logs();
        for (int i = 0; i < 2; i++) begin
            rq0.push_back({1'($urandom_range(0, 1)), 16'($urandom)});
            rq1.push_back({1'($urandom_range(0, 1)), 16'($urandom)});
        end
        wait_rsp(4, ok);
        n_checks++; if (!ok || exp_q.size() < 4) $display("FAIL alt_timeout got=%0d rsp want=4", rsp_q.size()); else n_pass++;
        if (ok && exp_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (rsp_q[i].id !== want_ids[i] || rsp_q[i].id !== exp_q[i].id || rsp_q[i].cnt !== exp_q[i].cnt)
                    $display("FAIL alt_rsp%0d got id=%0d cnt=%0d want id=%0d cnt=%0d", i, rsp_q[i].id, rsp_q[i].cnt, want_ids[i], exp_q[i].cnt);
                else n_pass++;
            end
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (acc_q[i].cyc - acc_q[i-1].cyc !== K + 2) $display("FAIL alt_spacing%0d got=%0d want=%0d", i, acc_q[i].cyc - acc_q[i-1].cyc, K + 2);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen = 1'b0;
        int cap_id, cap_cnt;
        clear_logs();
        @(posedge clk); #1 rsp_ready = 1'b0;
        rq0.push_back({1'($urandom_range(0, 1)), 16'($urandom)});
        rq1.push_back({1'($urandom_range(0, 1)), 16'($urandom)});
        for (int t = 0; t < 50 && !seen; t++) begin @(negedge clk); seen = (rsp_valid === 1'b1); end
        n_checks++; if (!seen) $display("FAIL bp_timeout got rsp_valid=%b want=1", rsp_valid); else n_pass++;
        cap_id = int'(rsp_id); cap_cnt = int'(rsp_count);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || int'(rsp_id) !== cap_id || int'(rsp_count) !== cap_cnt || req_ready !== '0)
                $display("FAIL bp_hold%0d got v=%b id=%0d cnt=%0d rdy=%b want v=1 id=%0d cnt=%0d rdy=00", c, rsp_valid, rsp_id, rsp_count, req_ready, cap_id, cap_cnt);
            else n_pass++;
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_rsp(2, ok);
        n_checks++; if (!ok || exp_q.size() < 2) $display("FAIL bp_drain got=%0d rsp want=2", rsp_q.size()); else n_pass++;
        if (ok && exp_q.size() >= 2) begin
            n_checks++; if (acc_q[1].cyc !== rsp_q[0].cyc + 1 || acc_q[1].gnt !== 1) $display("FAIL bp_next_accept got cyc=%0d gnt=%0d want cyc=%0d gnt=1", acc_q[1].cyc, acc_q[1].gnt, rsp_q[0].cyc + 1); else n_pass++;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (rsp_q[i].id !== exp_q[i].id || rsp_q[i].cnt !== exp_q[i].cnt) $display("FAIL bp_rsp%0d got id=%0d cnt=%0d want id=%0d cnt=%0d", i, rsp_q[i].id, rsp_q[i].cnt, exp_q[i].id, exp_q[i].cnt);
                else n_pass++;
            end
        end
        n_checks++; if (hold_viol !== 0) $display("FAIL bp_stability got=%0d violations want=0", hold_viol); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        clear_logs();
        rq0.push_back({1'b1, 16'($urandom)});
        rq1.push_back({1'($urandom_range(0, 1)), 16'($urandom)});
        for (int t = 0; t < 50 && !seen; t++) begin @(negedge clk); seen = (acc_q.size() > 0); end
        n_checks++; if (!seen) $display("FAIL rmid_accept_timeout got=0 accepts want=1"); else n_pass++;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_count !== '0)
            $display("FAIL rmid_outputs got v=%b id=%0d cnt=%0d want 0/0/0", rsp_valid, rsp_id, rsp_count);
        else n_pass++;
        clear_logs();
        m_last = NREQ - 1; prev_v = 1'b0; prev_r = 1'b0; pend_pop = '0;
        rq0.push_back({1'b0, 16'($urandom)});
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_rsp(2, ok);
        repeat (20) @(negedge clk);
        n_checks++; if (!ok || rsp_q.size() !== 2 || exp_q.size() < 2) $display("FAIL rmid_count got=%0d rsp want=2", rsp_q.size()); else n_pass++;
        if (ok && rsp_q.size() == 2 && exp_q.size() >= 2) begin
            n_checks++; if (acc_q[0].gnt !== 0) $display("FAIL rmid_first_grant got=%0d want=0", acc_q[0].gnt); else n_pass++;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (rsp_q[i].id !== exp_q[i].id || rsp_q[i].cnt !== exp_q[i].cnt) $display("FAIL rmid_rsp%0d got id=%0d cnt=%0d want id=%0d cnt=%0d", i, rsp_q[i].id, rsp_q[i].cnt, exp_q[i].id, exp_q[i].cnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int n = 16;
        clear_logs();
        hold_viol = 0; rdy_bad = 0;
        rdy_rand = 1'b1;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) rq0.push_back({1'($urandom_range(0, 1)), 16'($urandom)});
            else                           rq1.push_back({1'($urandom_range(0, 1)), 16'($urandom)});
        end
        wait_rsp(n, ok);
        rdy_rand = 1'b0;
        @(posedge clk); #1 rsp_ready = 1'b1;
        n_checks++; if (!ok || exp_q.size() < n || rise_q.size() < n) $display("FAIL rand_timeout got=%0d rsp want=%0d", rsp_q.size(), n); else n_pass++;
        if (ok && exp_q.size() >= n && rise_q.size() >= n) begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (rsp_q[i].id !== exp_q[i].id || rsp_q[i].cnt !== exp_q[i].cnt || acc_q[i].gnt !== acc_q[i].egnt || rise_q[i] - acc_q[i].cyc !== K + 1)
                    $display("FAIL rand_txn%0d got id=%0d cnt=%0d gnt=%0d lat=%0d want id=%0d cnt=%0d gnt=%0d lat=%0d", i, rsp_q[i].id, rsp_q[i].cnt, acc_q[i].gnt, rise_q[i] - acc_q[i].cyc, exp_q[i].id, exp_q[i].cnt, acc_q[i].egnt, K + 1);
                else n_pass++;
            end
        end
        n_checks++; if (hold_viol !== 0 || rdy_bad !== 0) $display("FAIL rand_protocol got hold=%0d ready=%0d want 0/0", hold_viol, rdy_bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_match_zero();
        test_alternate();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
